// File: rtl/c1_write_sequencer.sv
// c1_write_sequencer: fenced CCI-P c1 write sequencer; a status write waits for every earlier bulk write to be acknowledged
module c1_write_sequencer #(
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bulk_valid,
  input  logic [ADDR_W-1:0] bulk_addr,
  input  logic [DATA_W-1:0] bulk_data,
  output logic              bulk_ready,
  input  logic              stat_valid,
  input  logic [ADDR_W-1:0] stat_addr,
  input  logic [DATA_W-1:0] stat_data,
  output logic              stat_ready,
  input  logic              c1TxAlmFull,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] tx_addr,
  output logic [DATA_W-1:0] tx_data,
  output logic [15:0]       tx_mdata,
  input  logic              rsp_valid,
  input  logic              rsp_format,
  input  logic [1:0]        rsp_cl_num,
  output logic [CNT_W-1:0]  outstanding,
  output logic [CNT_W-1:0]  bulk_issued,
  output logic              stat_done,
  output logic              busy,
  output logic              err
);
  localparam int CW = CNT_W + 1;
  typedef enum logic [1:0] {STREAM, FENCE, STAT_ISSUE, STAT_WAIT} state_t;
  state_t state_q;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, bulk_issued_q;
  logic [ADDR_W-1:0] tx_addr_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [15:0] tx_mdata_q;
  logic tx_valid_q, stat_done_q, err_q;
  logic [CW-1:0] sum_d, dec_d;
  logic under_d, drained_d, bulk_acc;
  // the write on tx this cycle counts as in flight, so back-to-back issue never overshoots the limit
  assign sum_d = {1'b0, outstanding_q} + CW'(tx_valid_q);
  assign dec_d = !rsp_valid ? '0 : rsp_format ? CW'(rsp_cl_num) + CW'(1) : CW'(1);
  assign under_d = dec_d > sum_d;
  assign outstanding_d = under_d ? '0 : CNT_W'(sum_d - dec_d);
  assign drained_d = outstanding_q == '0 && !tx_valid_q;
  assign bulk_ready = !reset && state_q == STREAM && !stat_valid && !c1TxAlmFull
                      && sum_d < CW'(MAX_OUTSTANDING);
  assign stat_ready = !reset && state_q == STAT_ISSUE && !c1TxAlmFull;
  assign bulk_acc = bulk_valid && bulk_ready;
  assign tx_valid = tx_valid_q;
  assign tx_addr = tx_addr_q;
  assign tx_data = tx_data_q;
  assign tx_mdata = tx_mdata_q;
  assign outstanding = outstanding_q;
  assign bulk_issued = bulk_issued_q;
  assign stat_done = stat_done_q;
  assign err = err_q;
  assign busy = state_q != STREAM || outstanding_q != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STREAM;
      outstanding_q <= '0;
      bulk_issued_q <= '0;
      tx_valid_q <= 1'b0;
      tx_addr_q <= '0;
      tx_data_q <= '0;
      tx_mdata_q <= '0;
      stat_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q <= err_q | under_d;
      tx_valid_q <= bulk_acc || stat_ready;
      stat_done_q <= state_q == STAT_WAIT && drained_d;
      if (bulk_acc) begin
        tx_addr_q <= bulk_addr;
        tx_data_q <= bulk_data;
        tx_mdata_q <= 16'h0000;
        bulk_issued_q <= bulk_issued_q + 1'b1;
      end else if (stat_ready) begin
        tx_addr_q <= stat_addr;
        tx_data_q <= stat_data;
        tx_mdata_q <= 16'h0001;
      end
      case (state_q)
        STREAM:     if (stat_valid) state_q <= FENCE;
        FENCE:      if (drained_d) state_q <= STAT_ISSUE;
        STAT_ISSUE: if (!c1TxAlmFull) state_q <= STAT_WAIT;
        STAT_WAIT:  if (drained_d) state_q <= STREAM;
        default:    state_q <= STREAM;
      endcase
    end
  end
endmodule

// File: tb/tb_c1_write_sequencer.sv
// tb_c1_write_sequencer: directed vectors; tx requests checked by a scoreboard monitor, status signals checked inline
module tb_c1_write_sequencer;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bulk_valid = 1'b1, stat_valid = 1'b0, c1TxAlmFull = 1'b0;
  logic [AW-1:0] bulk_addr = AW'(32'h55), stat_addr = '0;
  logic [DW-1:0] bulk_data = '0, stat_data = '0;
  logic rsp_valid = 1'b0, rsp_format = 1'b0;
  logic [1:0] rsp_cl_num = 2'd0;
  logic bulk_ready, stat_ready, tx_valid, stat_done, busy, err;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_data;
  logic [15:0] tx_mdata;
  logic [CW-1:0] outstanding, bulk_issued;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0] mdata;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  int vecs = 0, errs = 0, mvecs = 0, merrs = 0;
  always #5 clk = ~clk;
  c1_write_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .bulk_valid(bulk_valid), .bulk_addr(bulk_addr), .bulk_data(bulk_data), .bulk_ready(bulk_ready),
    .stat_valid(stat_valid), .stat_addr(stat_addr), .stat_data(stat_data), .stat_ready(stat_ready),
    .c1TxAlmFull(c1TxAlmFull),
    .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_data(tx_data), .tx_mdata(tx_mdata),
    .rsp_valid(rsp_valid), .rsp_format(rsp_format), .rsp_cl_num(rsp_cl_num),
    .outstanding(outstanding), .bulk_issued(bulk_issued),
    .stat_done(stat_done), .busy(busy), .err(err)
  );
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(a);
    return {16{w}};
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_tx(input logic [AW-1:0] a, input logic [15:0] m);
    sb.push_back('{addr: a, mdata: m, data: pat(a)});
  endtask
  task automatic issue(input logic [AW-1:0] a);
    bulk_valid = 1'b1;
    bulk_addr = a;
    bulk_data = pat(a);
    #1 chk("bulk_ready_at_issue", 64'(bulk_ready), 64'd1);
    expect_tx(a, 16'h0000);
    cyc();
    chk("tx_valid_after_accept", 64'(tx_valid), 64'd1);
    chk("tx_addr_after_accept", 64'(tx_addr), 64'(a));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (tx_valid) begin
      mvecs++;
      if (sb.size() == 0) begin
        merrs++;
        $display("FAIL tx_unexpected: got addr %0h mdata %0h want no request", tx_addr, tx_mdata);
      end else begin
        e = sb.pop_front();
        if (tx_addr !== e.addr || tx_mdata !== e.mdata || tx_data !== e.data) begin
          merrs++;
          $display("FAIL tx_scoreboard: got addr %0h mdata %0h data[63:0] %0h want addr %0h mdata %0h data[63:0] %0h",
                   tx_addr, tx_mdata, tx_data[63:0], e.addr, e.mdata, e.data[63:0]);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_bulk_ready", 64'(bulk_ready), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_bulk_issued", 64'(bulk_issued), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
    end
    reset = 1'b0;
    bulk_valid = 1'b0;
    #1 chk("ready_after_reset", 64'(bulk_ready), 64'd1);
    for (int i = 0; i < 4; i++) issue(AW'(32'h100 + i));
    bulk_valid = 1'b0;
    cyc();
    chk("stream_tx_idle", 64'(tx_valid), 64'd0);
    chk("stream_outstanding4", 64'(outstanding), 64'd4);
    rsp_valid = 1'b1;
    repeat (4) cyc();
    rsp_valid = 1'b0;
    chk("stream_drained", 64'(outstanding), 64'd0);
    chk("stream_issued4", 64'(bulk_issued), 64'd4);
    chk("stream_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) issue(AW'(32'h180 + i));
    bulk_valid = 1'b0;
    cyc();
    chk("fence_outstanding3", 64'(outstanding), 64'd3);
    stat_valid = 1'b1;
    stat_addr = AW'(32'h200);
    stat_data = pat(AW'(32'h200));
    expect_tx(AW'(32'h200), 16'h0001);
    #1 chk("fence_bulk_ready", 64'(bulk_ready), 64'd0);
    chk("fence_stat_ready_early", 64'(stat_ready), 64'd0);
    rsp_valid = 1'b1;
    cyc();
    chk("fence_stat_ready_wait", 64'(stat_ready), 64'd0);
    chk("fence_busy", 64'(busy), 64'd1);
    cyc();
    cyc();
    rsp_valid = 1'b0;
    #1 chk("fence_stat_ready_last_rsp", 64'(stat_ready), 64'd0);
    chk("fence_drained", 64'(outstanding), 64'd0);
    cyc();
    chk("fence_stat_ready_pulse", 64'(stat_ready), 64'd1);
    chk("fence_no_tx_yet", 64'(tx_valid), 64'd0);
    cyc();
    stat_valid = 1'b0;
    chk("stat_tx_valid", 64'(tx_valid), 64'd1);
    chk("stat_tx_addr", 64'(tx_addr), 64'h200);
    chk("stat_tx_mdata", 64'(tx_mdata), 64'd1);
    chk("stat_ready_dropped", 64'(stat_ready), 64'd0);
    cyc();
    chk("stat_outstanding1", 64'(outstanding), 64'd1);
    chk("stat_done_early", 64'(stat_done), 64'd0);
    rsp_valid = 1'b1;
    cyc();
    rsp_valid = 1'b0;
    chk("stat_done_not_yet", 64'(stat_done), 64'd0);
    cyc();
    chk("stat_done_pulse", 64'(stat_done), 64'd1);
    chk("stat_bulk_ready_back", 64'(bulk_ready), 64'd1);
    cyc();
    chk("stat_done_cleared", 64'(stat_done), 64'd0);
    c1TxAlmFull = 1'b1;
    bulk_valid = 1'b1;
    bulk_addr = AW'(32'h300);
    bulk_data = pat(AW'(32'h300));
    for (int i = 0; i < 5; i++) begin
      #1 chk("almfull_ready", 64'(bulk_ready), 64'd0);
      cyc();
      chk("almfull_no_tx", 64'(tx_valid), 64'd0);
    end
    c1TxAlmFull = 1'b0;
    for (int i = 0; i < 4; i++) issue(AW'(32'h300 + i));
    bulk_valid = 1'b0;
    cyc();
    chk("limit_outstanding4", 64'(outstanding), 64'd4);
    bulk_valid = 1'b1;
    bulk_addr = AW'(32'h400);
    bulk_data = pat(AW'(32'h400));
    #1 chk("limit_ready_low", 64'(bulk_ready), 64'd0);
    cyc();
    chk("limit_no_tx", 64'(tx_valid), 64'd0);
    rsp_valid = 1'b1;
    rsp_format = 1'b1;
    rsp_cl_num = 2'd3;
    #1 chk("limit_ready_before_rsp", 64'(bulk_ready), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    rsp_format = 1'b0;
    rsp_cl_num = 2'd0;
    #1 chk("packed_drained", 64'(outstanding), 64'd0);
    chk("limit_ready_after_rsp", 64'(bulk_ready), 64'd1);
    issue(AW'(32'h400));
    issue(AW'(32'h401));
    bulk_valid = 1'b0;
    chk("simul_pre_outstanding", 64'(outstanding), 64'd1);
    rsp_valid = 1'b1;
    cyc();
    chk("simul_outstanding", 64'(outstanding), 64'd1);
    chk("simul_err", 64'(err), 64'd0);
    cyc();
    chk("simul_drained", 64'(outstanding), 64'd0);
    cyc();
    rsp_valid = 1'b0;
    chk("underflow_err", 64'(err), 64'd1);
    chk("underflow_outstanding", 64'(outstanding), 64'd0);
    cyc();
    chk("err_sticky", 64'(err), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("issued_total", 64'(bulk_issued), 64'd13);
    issue(AW'(32'h500));
    bulk_valid = 1'b0;
    reset = 1'b1;
    cyc();
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_issued", 64'(bulk_issued), 64'd0);
    chk("midrst_ready", 64'(bulk_ready), 64'd0);
    reset = 1'b0;
    #1 chk("midrst_ready_after", 64'(bulk_ready), 64'd1);
    cyc();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs + mvecs, errs + merrs);
    $finish;
  end
endmodule
